// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART_TX handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   REQ_VALID;
  logic [8*N-1:0] REQ_DATA;
  logic [N-1:0]   REQ_LAST;
  logic [N-1:0]   REQ_READY;
  logic [N-1:0]   GRANT;
  logic           TX_START;
  logic [7:0]     TX_DATA;
  logic           TX_BUSY;
  logic           ERR_TOUT;

  modport master (
    output REQ_VALID, REQ_DATA, REQ_LAST, TX_BUSY,
    input  REQ_READY, GRANT, TX_START, TX_DATA, ERR_TOUT
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_LAST, TX_BUSY,
    output REQ_READY, GRANT, TX_START, TX_DATA, ERR_TOUT
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one UART transmitter among N byte streams.
// Each accepted byte gets a one-cycle start strobe, then busy is tracked high and low.
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int BUSY_WAIT = 4
) (
  input logic              SYSCLK,
  input logic              RST_B,
  uart_tx_arbiter_if.slave bus
);
  localparam int             W        = $clog2(N);
  localparam logic [1:0]     IDLE     = 2'd0;
  localparam logic [1:0]     XFER     = 2'd1;
  localparam logic [1:0]     WAIT_HI  = 2'd2;
  localparam logic [1:0]     WAIT_LO  = 2'd3;
  localparam logic [3:0]     CNT_LAST = 4'(BUSY_WAIT - 1);
  localparam logic [N-1:0]   ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state_r;
  logic [W-1:0] ptr_r;
  logic [W-1:0] owner_r;
  logic [3:0]   cnt_r;
  logic         last_r;
  logic [N-1:0] ready_r;
  logic [N-1:0] grant_r;
  logic         start_r;
  logic [7:0]   data_r;
  logic         err_r;

  logic [W:0]   idx_s;
  logic [W-1:0] sel_s;
  logic         any_s;
  logic         accept_s;

  assign bus.REQ_READY = ready_r;
  assign bus.GRANT     = grant_r;
  assign bus.TX_START  = start_r;
  assign bus.TX_DATA   = data_r;
  assign bus.ERR_TOUT  = err_r;

  // Round-robin pick: scan downward from ptr+N to ptr+1 so the nearest valid after ptr wins.
  always_comb begin
    sel_s = ptr_r;
    idx_s = {(W+1){1'b0}};
    for (int k = N; k >= 1; k--) begin
      idx_s = {1'b0, ptr_r} + (W+1)'(k);
      idx_s = (idx_s >= (W+1)'(N)) ? idx_s - (W+1)'(N) : idx_s;
      sel_s = bus.REQ_VALID[idx_s[W-1:0]] ? idx_s[W-1:0] : sel_s;
    end
    any_s    = |bus.REQ_VALID;
    accept_s = bus.REQ_VALID[owner_r] & ~bus.TX_BUSY;
  end

  // Arbitration / byte sequencing FSM with all outputs registered.
  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_r <= IDLE;
      ptr_r   <= W'(N - 1);
      owner_r <= {W{1'b0}};
      cnt_r   <= 4'd0;
      last_r  <= 1'b0;
      ready_r <= {N{1'b0}};
      grant_r <= {N{1'b0}};
      start_r <= 1'b0;
      data_r  <= 8'hFF;
      err_r   <= 1'b0;
    end else begin
      ready_r <= {N{1'b0}};
      start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            grant_r <= ONE_HOT0 << sel_s;
            owner_r <= sel_s;
            state_r <= XFER;
          end
        end
        XFER: begin
          if (accept_s) begin
            ready_r <= ONE_HOT0 << owner_r;
            data_r  <= bus.REQ_DATA[{owner_r, 3'b000} +: 8];
            start_r <= 1'b1;
            last_r  <= bus.REQ_LAST[owner_r];
            cnt_r   <= 4'd0;
            state_r <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          // A transmitter that never goes busy is flagged, then treated as finished.
          if (bus.TX_BUSY) begin
            state_r <= WAIT_LO;
          end else if (cnt_r == CNT_LAST) begin
            err_r   <= 1'b1;
            state_r <= WAIT_LO;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        WAIT_LO: begin
          if (!bus.TX_BUSY) begin
            if (last_r) begin
              grant_r <= {N{1'b0}};
              ptr_r   <= owner_r;
              state_r <= IDLE;
            end else begin
              state_r <= XFER;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule
